// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU sequencer/arbiter
package alu_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } alu_arb_state_e;

   typedef enum logic [3:0] {
      MODE_ADD   = 4'd0,
      MODE_SUB   = 4'd1,
      MODE_PASS1 = 4'd2,
      MODE_PASS2 = 4'd3,
      MODE_AND   = 4'd4,
      MODE_OR    = 4'd5,
      MODE_XOR   = 4'd6,
      MODE_MUL   = 4'd7,
      MODE_INC2  = 4'd8,
      MODE_INC1  = 4'd9,
      MODE_ROL   = 4'd10,
      MODE_ROR   = 4'd11,
      MODE_SHL2  = 4'd12,
      MODE_SHR2  = 4'd13,
      MODE_ASR3  = 4'd14,
      MODE_NEG   = 4'd15
   } alu_mode_e;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_O = 1;
   localparam int FLAG_S = 0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - request vector to one-hot grant and index, round-robin pointer
// ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins priority and drops the pointer.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_advance,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_grant_idx,
   output logic            o_grant_valid
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic w_unused;
   assign w_unused = i_clk ^ i_rst_n ^ i_advance;

   // Scan downward so the lowest valid index is the last one written.
   always_comb begin
      o_grant_valid = 1'b0;
      o_grant_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (i_req[IDW'(i)]) begin
            o_grant_valid = 1'b1;
            o_grant_idx   = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] r_ptr;
   logic [IDW:0]   w_sum;
   logic [IDW-1:0] w_pos;

   // Search begins at the pointer and wraps from NREQ-1 back to 0.
   always_comb begin
      o_grant_valid = 1'b0;
      o_grant_idx   = '0;
      w_sum         = '0;
      w_pos         = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
         if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
         end
         w_pos = w_sum[IDW-1:0];
         if (!o_grant_valid && i_req[w_pos]) begin
            o_grant_valid = 1'b1;
            o_grant_idx   = w_pos;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_advance && o_grant_valid) begin
         r_ptr <= (o_grant_idx == IDW'(NREQ - 1)) ? '0 : o_grant_idx + IDW'(1);
      end
   end
`endif

   assign o_grant = o_grant_valid ? (NREQ'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one 8-bit ALU among NREQ requesters, id-tagged responses
// ALU_ARB_FIXED_PRIO_EN (in rr_arbiter) switches round-robin to fixed priority.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*4-1:0] req_mode,
   input  logic [NREQ*8-1:0] req_op1,
   input  logic [NREQ*8-1:0] req_op2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_result,
   output logic [3:0]        rsp_flag,
   output logic              alu_enable,
   output logic [3:0]        alu_mode,
   output logic [7:0]        alu_op1,
   output logic [7:0]        alu_op2,
   input  logic [7:0]        alu_result,
   input  logic [3:0]        alu_flag
);

   alu_arb_state_e r_state;
   alu_arb_state_e w_next;

   logic [3:0]     r_mode;
   logic [7:0]     r_op1;
   logic [7:0]     r_op2;
   logic [IDW-1:0] r_id;

   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_idx;
   logic            w_found;
   logic            w_can_grant;
   logic            w_accept;

   logic [3:0] w_mode_arr [NREQ];
   logic [7:0] w_op1_arr  [NREQ];
   logic [7:0] w_op2_arr  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_mode_arr[g] = req_mode[g*4 +: 4];
      assign w_op1_arr[g]  = req_op1[g*8 +: 8];
      assign w_op2_arr[g]  = req_op2[g*8 +: 8];
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req         (req_valid),
      .i_advance     (w_accept),
      .o_grant       (w_grant),
      .o_grant_idx   (w_idx),
      .o_grant_valid (w_found)
   );

   // Reset is folded in so a handshake coinciding with reset is never offered.
   assign w_can_grant = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
   assign w_accept    = w_can_grant && w_found;
   assign req_ready   = w_can_grant ? w_grant : '0;

   always_comb begin
      w_next     = r_state;
      alu_enable = 1'b0;
      alu_mode   = 4'd0;
      alu_op1    = 8'd0;
      alu_op2    = 8'd0;
      rsp_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_enable = 1'b1;
            alu_mode   = r_mode;
            alu_op1    = r_op1;
            alu_op2    = r_op2;
            w_next     = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next = w_accept ? ST_EXEC : ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_mode     <= 4'd0;
         r_op1      <= 8'd0;
         r_op2      <= 8'd0;
         r_id       <= '0;
         rsp_id     <= '0;
         rsp_result <= 8'd0;
         rsp_flag   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mode <= w_mode_arr[w_idx];
            r_op1  <= w_op1_arr[w_idx];
            r_op2  <= w_op2_arr[w_idx];
            r_id   <= w_idx;
         end
         // ALU is combinational beside us; its outputs are valid during EXEC.
         if (r_state == ST_EXEC) begin
            rsp_id     <= r_id;
            rsp_result <= alu_result;
            rsp_flag   <= alu_flag;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a stand-in ALU
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0][3:0] req_mode;
   logic [NREQ-1:0][7:0] req_op1;
   logic [NREQ-1:0][7:0] req_op2;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [7:0]           rsp_result;
   logic [3:0]           rsp_flag;
   logic                 alu_enable;
   logic [3:0]           alu_mode;
   logic [7:0]           alu_op1;
   logic [7:0]           alu_op2;
   logic [7:0]           alu_result;
   logic [3:0]           alu_flag;

   alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mode   (req_mode),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flag   (rsp_flag),
      .alu_enable (alu_enable),
      .alu_mode   (alu_mode),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_result (alu_result),
      .alu_flag   (alu_flag)
   );

   // Stand-in ALU: O mirrors C, all outputs zero while disabled.
   logic [15:0] stub_wide;
   logic        stub_c;
   always_comb begin
      stub_wide  = 16'd0;
      stub_c     = 1'b0;
      alu_result = 8'd0;
      alu_flag   = 4'd0;
      if (alu_enable) begin
         case (alu_mode)
            MODE_ADD:   begin stub_wide = 16'(alu_op1) + 16'(alu_op2); stub_c = stub_wide[8]; end
            MODE_SUB:   begin stub_wide = 16'(alu_op1) - 16'(alu_op2); stub_c = stub_wide[8]; end
            MODE_AND:   stub_wide = 16'(alu_op1 & alu_op2);
            MODE_XOR:   stub_wide = 16'(alu_op1 ^ alu_op2);
            MODE_PASS1: stub_wide = 16'(alu_op1);
            MODE_MUL:   begin stub_wide = 16'(alu_op1) * 16'(alu_op2); stub_c = |stub_wide[15:8]; end
            default:    stub_wide = 16'd0;
         endcase
         alu_result         = stub_wide[7:0];
         alu_flag[FLAG_Z]   = (stub_wide[7:0] == 8'd0);
         alu_flag[FLAG_C]   = stub_c;
         alu_flag[FLAG_O]   = stub_c;
         alu_flag[FLAG_S]   = stub_wide[7];
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
      chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
      chk({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
      chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
      chk({tag, "_rsp_flag"},   32'(rsp_flag),   32'd0);
      chk({tag, "_alu_enable"}, 32'(alu_enable), 32'd0);
      chk({tag, "_alu_mode"},   32'(alu_mode),   32'd0);
      chk({tag, "_alu_op1"},    32'(alu_op1),    32'd0);
      chk({tag, "_alu_op2"},    32'(alu_op2),    32'd0);
   endtask

   task automatic set_req(input logic [IDW-1:0] id, input alu_mode_e m,
                          input logic [7:0] a, input logic [7:0] b);
      req_mode[id] = m;
      req_op1[id]  = a;
      req_op2[id]  = b;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [IDW-1:0] id;
      alu_mode_e      mode;
      logic [7:0]     op1;
      logic [7:0]     op2;
      logic [7:0]     res;
      logic [3:0]     flag;
   } vec_t;

   vec_t vecs [7];
   int   exp_order [6];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{2'd1, MODE_ADD,   8'hFF, 8'h01, 8'h00, 4'b1110};
      vecs[1] = '{2'd0, MODE_SUB,   8'h05, 8'h03, 8'h02, 4'b0000};
      vecs[2] = '{2'd2, MODE_SUB,   8'h03, 8'h05, 8'hFE, 4'b0111};
      vecs[3] = '{2'd3, MODE_AND,   8'hF0, 8'h3C, 8'h30, 4'b0000};
      vecs[4] = '{2'd1, MODE_XOR,   8'hAA, 8'hAA, 8'h00, 4'b1000};
      vecs[5] = '{2'd2, MODE_MUL,   8'h10, 8'h20, 8'h00, 4'b1110};
      vecs[6] = '{2'd0, MODE_PASS1, 8'h80, 8'h11, 8'h80, 4'b0001};
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0, 1};
`endif

      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_mode  = '0;
      req_op1   = '0;
      req_op2   = '0;
      @(negedge clk);
      @(negedge clk);
      chk_reset_values("rst");

      // A request offered while reset is low must not be accepted.
      req_valid = 4'b0001;
      #1;
      chk("rst_coincide_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rst_coincide_no_exec", 32'(alu_enable), 32'd0);
      req_valid = '0;
      rst_n     = 1'b1;

      // Single operations: grant, one EXEC cycle, response two cycles after handshake.
      rsp_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         set_req(vecs[v].id, vecs[v].mode, vecs[v].op1, vecs[v].op2);
         req_valid = 4'b0001 << vecs[v].id;
         #1;
         chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(4'b0001 << vecs[v].id));
         chk($sformatf("v%0d_no_alu_idle", v), 32'(alu_enable), 32'd0);
         @(negedge clk);
         req_valid = '0;
         chk($sformatf("v%0d_alu_en", v),   32'(alu_enable), 32'd1);
         chk($sformatf("v%0d_alu_mode", v), 32'(alu_mode),   32'(vecs[v].mode));
         chk($sformatf("v%0d_alu_op1", v),  32'(alu_op1),    32'(vecs[v].op1));
         chk($sformatf("v%0d_alu_op2", v),  32'(alu_op2),    32'(vecs[v].op2));
         chk($sformatf("v%0d_no_rsp_exec", v), 32'(rsp_valid), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_rsp_valid", v),  32'(rsp_valid),  32'd1);
         chk($sformatf("v%0d_rsp_id", v),     32'(rsp_id),     32'(vecs[v].id));
         chk($sformatf("v%0d_rsp_result", v), 32'(rsp_result), 32'(vecs[v].res));
         chk($sformatf("v%0d_rsp_flag", v),   32'(rsp_flag),   32'(vecs[v].flag));
         chk($sformatf("v%0d_alu_zero", v),   32'({alu_mode, alu_op1, alu_op2}), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_rsp_done", v), 32'(rsp_valid), 32'd0);
      end

      // Arbitration order with requesters held valid continuously.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(IDW'(i), MODE_PASS1, 8'(i + 8'h40), 8'h00);
`ifdef ALU_ARB_FIXED_PRIO_EN
      req_valid = 4'b0101;
`else
      req_valid = 4'b1111;
`endif
      rsp_ready = 1'b1;
      begin
         int ngrant, cyc, last_cyc, last_id, gid;
         ngrant = 0; cyc = 0; last_cyc = 0; last_id = 0; gid = 0;
         while (ngrant < 6 && cyc < 40) begin
            #1;
            chk("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (rsp_valid) chk("rr_rsp_id", 32'(rsp_id), 32'(last_id));
            if (req_ready != '0) begin
               for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid = k;
               chk($sformatf("rr_grant%0d", ngrant), 32'(gid), 32'(exp_order[ngrant]));
               if (ngrant > 0) chk($sformatf("rr_gap%0d", ngrant), 32'(cyc - last_cyc), 32'd2);
               last_cyc = cyc;
               last_id  = gid;
               ngrant++;
            end
            @(negedge clk);
            cyc++;
         end
         chk("rr_count", 32'(ngrant), 32'd6);
      end
      req_valid = '0;
      repeat (3) @(negedge clk);

      // Response backpressure stalls every requester; release grants in the same cycle.
      do_reset();
      set_req(2'd1, MODE_ADD, 8'h01, 8'h02);
      set_req(2'd2, MODE_SUB, 8'h09, 8'h04);
      set_req(2'd3, MODE_AND, 8'h00, 8'h00);
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      #1;
      chk("bp_first_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = 4'b1100;
      rsp_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_valid", s),  32'(rsp_valid),  32'd1);
         chk($sformatf("bp%0d_id", s),     32'(rsp_id),     32'd1);
         chk($sformatf("bp%0d_result", s), 32'(rsp_result), 32'h03);
         chk($sformatf("bp%0d_flag", s),   32'(rsp_flag),   32'd0);
         chk($sformatf("bp%0d_ready", s),  32'(req_ready),  32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0100);
      chk("bp_release_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      req_valid = '0;
      chk("bp_exec2_en",  32'(alu_enable), 32'd1);
      chk("bp_exec2_op1", 32'(alu_op1),    32'h09);
      @(negedge clk);
      chk("bp_rsp2_id",     32'(rsp_id),     32'd2);
      chk("bp_rsp2_result", 32'(rsp_result), 32'h05);
      @(negedge clk);
      chk("bp_idle", 32'(rsp_valid), 32'd0);

      // Reset during EXEC: operation dropped, pointer back to 0.
      set_req(2'd1, MODE_ADD, 8'h07, 8'h07);
      req_valid = 4'b0010;
      #1;
      chk("mid_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      chk("mid_exec", 32'(alu_enable), 32'd1);
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_values("mid");
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         chk($sformatf("mid_no_rsp%0d", s), 32'(rsp_valid), 32'd0);
      end
      set_req(2'd0, MODE_PASS1, 8'h01, 8'h00);
      set_req(2'd3, MODE_PASS1, 8'h03, 8'h00);
      req_valid = 4'b1001;
      #1;
      chk("mid_ptr_reset", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk("mid_final_id", 32'(rsp_id), 32'd0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
